// File: rtl/seq_multiplier.sv
// Radix-2 sequential 32x32 multiplier with optional signed mode and 64-bit accumulate.
// One operation takes 33 cycles: 32 shift-add iterations followed by one sign/accumulate adjust cycle.
module seq_multiplier (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_Start,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_LongMulSig,
  input  logic        in_AccEn,
  input  logic [31:0] in_AccHigh,
  input  logic [31:0] in_AccLow,
  output logic [63:0] out_MulResult,
  output logic        out_Busy,
  output logic        out_Done,
  output logic        out_Zero,
  output logic        out_Neg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ADJUST = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] mcand_q, mcand_d;
  logic [32:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;
  logic        sign_q, sign_d;
  logic        acc_en_q, acc_en_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;

  // 33-bit magnitudes so that signed 0x80000000 converts without overflow
  logic [32:0] mag_a, mag_b;
  logic [63:0] signed_prod, final_res;

  always_comb begin
    mag_a = (in_LongMulSig && in_a[31]) ? (~{in_a[31], in_a} + 33'd1) : {1'b0, in_a};
    mag_b = (in_LongMulSig && in_b[31]) ? (~{in_b[31], in_b} + 33'd1) : {1'b0, in_b};
    signed_prod = sign_q ? (~prod_q + 64'd1) : prod_q;
    final_res   = signed_prod + (acc_en_q ? acc_q : 64'd0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    acc_en_d = acc_en_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (in_Start) begin
          mcand_d  = {31'd0, mag_a};
          mplier_d = mag_b;
          sign_d   = in_LongMulSig & (in_a[31] ^ in_b[31]);
          acc_en_d = in_AccEn;
          acc_d    = {in_AccHigh, in_AccLow};
          prod_d   = 64'd0;
          cnt_d    = 5'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ADJUST;
      end
      ADJUST: begin
        result_d = final_res;
        zero_d   = (final_res == 64'd0);
        neg_d    = final_res[63];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 33'd0;
      prod_q   <= 64'd0;
      sign_q   <= 1'b0;
      acc_en_q <= 1'b0;
      acc_q    <= 64'd0;
      result_q <= 64'd0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      acc_en_q <= acc_en_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign out_MulResult = result_q;
  assign out_Busy      = (state_q == BUSY) || (state_q == ADJUST);
  assign out_Done      = done_q;
  assign out_Zero      = zero_q;
  assign out_Neg       = neg_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_seq_multiplier;

  logic        clock;
  logic        reset;
  logic        in_Start;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_LongMulSig;
  logic        in_AccEn;
  logic [31:0] in_AccHigh;
  logic [31:0] in_AccLow;
  logic [63:0] out_MulResult;
  logic        out_Busy;
  logic        out_Done;
  logic        out_Zero;
  logic        out_Neg;

  int passCount = 0;
  int totalCount = 0;

  seq_multiplier dut (
    .clock         (clock),
    .reset         (reset),
    .in_Start      (in_Start),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_LongMulSig (in_LongMulSig),
    .in_AccEn      (in_AccEn),
    .in_AccHigh    (in_AccHigh),
    .in_AccLow     (in_AccLow),
    .out_MulResult (out_MulResult),
    .out_Busy      (out_Busy),
    .out_Done      (out_Done),
    .out_Zero      (out_Zero),
    .out_Neg       (out_Neg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full 64-bit product computed directly from the operand interpretation
  function automatic logic [63:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic sig, input logic accEn, input logic [63:0] acc);
    logic [63:0] p;
    longint sp;
    if (sig) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = 64'(sp);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return p + (accEn ? acc : 64'd0);
  endfunction

  // Start one operation, scramble inputs while busy, and report cycles to Done
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sig,
                               input logic accEn, input logic [63:0] acc, output int latency);
    in_a = a; in_b = b; in_LongMulSig = sig; in_AccEn = accEn;
    {in_AccHigh, in_AccLow} = acc;
    in_Start = 1'b1;
    tick();
    in_Start = 1'b0;
    checkOutput("busy_after_start", 64'(out_Busy), 64'd1);
    latency = -1;
    for (int n = 1; n <= 60; n++) begin
      in_a = $urandom; in_b = $urandom; in_LongMulSig = 1'($urandom);
      in_AccEn = 1'($urandom); in_AccHigh = $urandom; in_AccLow = $urandom;
      tick();
      if (out_Done) begin
        latency = n;
        break;
      end
    end
    checkOutput("latency", 64'(latency), 64'd33);
  endtask

  task automatic checkResult(input string tag, input logic [63:0] expected);
    checkOutput({tag, "_res"}, out_MulResult, expected);
    checkOutput({tag, "_zero"}, 64'(out_Zero), 64'(expected == 64'd0));
    checkOutput({tag, "_neg"}, 64'(out_Neg), 64'(expected[63]));
  endtask

  initial begin
    int lat;
    int doneCount;
    int firstDone;
    int secondDone;
    logic [31:0] ra, rb;
    logic rs, re;
    logic [63:0] racc;

    reset = 1'b0; in_Start = 1'b0; in_a = '0; in_b = '0;
    in_LongMulSig = 1'b0; in_AccEn = 1'b0; in_AccHigh = '0; in_AccLow = '0;
    #23;
    checkOutput("rst_res", out_MulResult, 64'd0);
    checkOutput("rst_busy", 64'(out_Busy), 64'd0);
    checkOutput("rst_done", 64'(out_Done), 64'd0);
    checkOutput("rst_zero", 64'(out_Zero), 64'd0);
    checkOutput("rst_neg", 64'(out_Neg), 64'd0);
    tick();
    reset = 1'b1;
    tick();

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'd0, lat);
    checkResult("unsigned_max", 64'hFFFF_FFFE_0000_0001);
    tick();
    checkOutput("done_one_cycle", 64'(out_Done), 64'd0);
    checkOutput("busy_idle", 64'(out_Busy), 64'd0);

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'd0, lat);
    checkResult("signed_m1", 64'h0000_0000_0000_0001);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 64'd0, lat);
    checkResult("signed_min", 64'h4000_0000_0000_0000);
    applyStimulus(32'd2, 32'd3, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, lat);
    checkResult("acc_zero", 64'd0);

    // Stray start mid-operation, then a start accepted on the Done cycle
    in_a = 32'd5; in_b = 32'd9; in_LongMulSig = 1'b0; in_AccEn = 1'b0;
    in_Start = 1'b1;
    tick();
    in_Start = 1'b0;
    doneCount = 0; firstDone = -1; secondDone = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == 10) begin
        in_a = 32'd7; in_b = 32'd7; in_Start = 1'b1;
      end
      tick();
      in_Start = 1'b0;
      if (out_Done) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = n;
          checkOutput("stray_start_res", out_MulResult, 64'd45);
          in_a = 32'd6; in_b = 32'd7; in_Start = 1'b1;
        end else begin
          secondDone = n;
          checkOutput("b2b_res", out_MulResult, 64'd42);
          break;
        end
      end
    end
    checkOutput("first_done_at", 64'(firstDone), 64'd33);
    checkOutput("b2b_gap", 64'(secondDone - firstDone), 64'd34);
    checkOutput("done_count", 64'(doneCount), 64'd2);

    // Asynchronous reset during iteration 10
    in_a = 32'd9; in_b = 32'd9; in_Start = 1'b1;
    tick();
    in_Start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_res", out_MulResult, 64'd0);
    checkOutput("midrst_busy", 64'(out_Busy), 64'd0);
    checkOutput("midrst_done", 64'(out_Done), 64'd0);
    checkOutput("midrst_zero", 64'(out_Zero), 64'd0);
    checkOutput("midrst_neg", 64'(out_Neg), 64'd0);
    doneCount = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (out_Done) doneCount++;
    end
    reset = 1'b1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (out_Done) doneCount++;
    end
    checkOutput("midrst_no_done", 64'(doneCount), 64'd0);
    applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, 64'd0, lat);
    checkResult("after_rst", 64'd12);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom); re = 1'($urandom);
      racc = {$urandom, $urandom};
      if (i % 5 == 0) ra = 32'h8000_0000;
      applyStimulus(ra, rb, rs, re, racc, lat);
      checkResult("rand", refModel(ra, rb, rs, re, racc));
      if (!re) checkOutput("rand_mul32", {32'd0, out_MulResult[31:0]}, {32'd0, ra * rb});
    end

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
